// File: rtl/p18_pkg.sv
// Shared types and constants for the icon row painter and its blink controller.
// cnt_width() sizes a counter that has to hold 0..maxval.
package p18_pkg;

  typedef logic [5:0] color_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ICON,
    GAP,
    DONE
  } hstate_e;

  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/p18_blink_ctrl.sv
// Per-frame bookkeeping for the icon row: frame tick, shown/prev counts and the
// blink countdown with its on/off phase for icons lost since the last frame.
module p18_blink_ctrl
  import p18_pkg::*;
#(
  parameter int MAX_ICONS    = 3,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8,
  localparam int CW          = cnt_width(MAX_ICONS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [8:0]    vpos_i,
  input  logic [CW-1:0] count_i,
  output logic [CW-1:0] shown_o,
  output logic [CW-1:0] prev_o,
  output logic          blinking_o,
  output logic          phase_o
);

  localparam int BW   = cnt_width(BLINK_FRAMES);
  localparam int HALF = (BLINK_HALF < 1) ? 1 : BLINK_HALF;
  localparam int DW   = cnt_width(HALF - 1);

  localparam logic [CW-1:0] MAX_C      = CW'(MAX_ICONS);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES);
  localparam logic [DW-1:0] DIV_LAST   = DW'(HALF - 1);

  logic          vpos0_q;
  logic          frame_tick;
  logic [CW-1:0] cnt;
  logic [CW-1:0] shown_q, shown_d;
  logic [CW-1:0] prev_q, prev_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;

  assign frame_tick = (vpos_i == '0) && !vpos0_q;
  assign cnt        = (int'(count_i) > MAX_ICONS) ? MAX_C : count_i;

  // A fresh loss restarts the blink; any gain or the final frame ends it.
  always_comb begin
    shown_d = shown_q;
    prev_d  = prev_q;
    blink_d = blink_q;
    div_d   = div_q;
    phase_d = phase_q;
    if (frame_tick) begin
      shown_d = cnt;
      if ((BLINK_FRAMES > 0) && (cnt < shown_q)) begin
        prev_d  = shown_q;
        blink_d = BLINK_LOAD;
        div_d   = '0;
        phase_d = 1'b1;
      end else begin
        if (blink_q != '0) begin
          blink_d = blink_q - 1'b1;
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            phase_d = !phase_q;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        if ((cnt >= prev_q) || (cnt > shown_q) || (blink_q == BW'(1))) begin
          prev_d  = cnt;
          blink_d = '0;
          div_d   = '0;
          phase_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vpos0_q <= 1'b0;
      shown_q <= '0;
      prev_q  <= '0;
      blink_q <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      vpos0_q <= (vpos_i == '0);
      shown_q <= shown_d;
      prev_q  <= prev_d;
      blink_q <= blink_d;
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign shown_o    = shown_q;
  assign prev_o     = prev_q;
  assign blinking_o = (blink_q != '0);
  assign phase_o    = phase_q;

endmodule

// File: rtl/p18_icon_row_painter.sv
// Paints a row of identical icons (lives, bombs) with blink-out of lost icons.
// Define P18_ICON_ROUND_CORNERS_EN to clip the four corner pixels of each icon.
module p18_icon_row_painter
  import p18_pkg::*;
#(
  parameter color_t COLOR     = 6'b111111,
  parameter int MAX_ICONS     = 3,
  parameter int ICON_W        = 24,
  parameter int ICON_H        = 4,
  parameter int SPACING       = 16,
  parameter int X_START       = 16,
  parameter int Y_POS         = 474,
  parameter int BLINK_FRAMES  = 60,
  parameter int BLINK_HALF    = 8,
  localparam int CW           = cnt_width(MAX_ICONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hactive,
  input  logic [9:0]    hpos,
  input  logic [8:0]    vpos,
  input  logic [CW-1:0] count,
  output logic          in_icon,
  output color_t        color
);

  localparam int CNT_MAX_A = (X_START > ICON_W) ? X_START - 1 : ICON_W - 1;
  localparam int CNT_MAX   = (CNT_MAX_A > SPACING - 1) ? CNT_MAX_A : SPACING - 1;
  localparam int TW        = cnt_width(CNT_MAX);

  localparam logic [TW-1:0] LEAD_LOAD = TW'(X_START - 1);
  localparam logic [TW-1:0] ICON_LOAD = TW'(ICON_W - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(SPACING - 1);
  localparam logic [9:0]    Y_TOP     = 10'(Y_POS);
  localparam logic [9:0]    Y_END     = 10'(Y_POS + ICON_H);

  hstate_e       state_q, state_d;
  logic [TW-1:0] ctr_q, ctr_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] limit_q;
  logic [CW-1:0] shown;
  logic [CW-1:0] prev;
  logic          blinking;
  logic          phase;
  logic [9:0]    vpos_ext;
  logic          in_y;
  logic          visible;
  logic          icon_px;
  logic          unused_hpos;

  p18_blink_ctrl #(
    .MAX_ICONS   (MAX_ICONS),
    .BLINK_FRAMES(BLINK_FRAMES),
    .BLINK_HALF  (BLINK_HALF)
  ) u_blink (
    .clk_i     (clk),
    .rst_i     (rst),
    .vpos_i    (vpos),
    .count_i   (count),
    .shown_o   (shown),
    .prev_o    (prev),
    .blinking_o(blinking),
    .phase_o   (phase)
  );

  // IDLE doubles as the first lead-in cycle so icon 0 lands on index X_START.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    if (!hactive) begin
      state_d = IDLE;
      ctr_d   = LEAD_LOAD;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, LEAD: begin
          if (ctr_q == '0) begin
            if (limit_q == '0) begin
              state_d = DONE;
            end else begin
              state_d = ICON;
              ctr_d   = ICON_LOAD;
            end
          end else begin
            state_d = LEAD;
            ctr_d   = ctr_q - 1'b1;
          end
        end
        ICON: begin
          if (ctr_q == '0) begin
            idx_d = idx_q + 1'b1;
            if ((idx_q + 1'b1) == limit_q) begin
              state_d = DONE;
            end else begin
              state_d = GAP;
              ctr_d   = GAP_LOAD;
            end
          end else begin
            ctr_d = ctr_q - 1'b1;
          end
        end
        GAP: begin
          if (ctr_q == '0) begin
            state_d = ICON;
            ctr_d   = ICON_LOAD;
          end else begin
            ctr_d = ctr_q - 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= LEAD_LOAD;
      idx_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      // Only sampled during blanking so a line never changes length mid-scan.
      if (!hactive) begin
        limit_q <= blinking ? prev : shown;
      end
    end
  end

  assign vpos_ext    = {1'b0, vpos};
  assign in_y        = (vpos_ext >= Y_TOP) && (vpos_ext < Y_END);
  assign visible     = (idx_q < shown) || phase;
  assign icon_px     = hactive && (state_q == ICON) && in_y && visible;
  assign unused_hpos = ^hpos;

`ifdef P18_ICON_ROUND_CORNERS_EN
  logic corner;
  assign corner  = (ICON_W >= 3) && (ICON_H >= 3) &&
                   ((ctr_q == ICON_LOAD) || (ctr_q == '0)) &&
                   ((vpos_ext == Y_TOP) || (vpos_ext == (Y_END - 10'd1)));
  assign in_icon = icon_px && !corner;
`else
  assign in_icon = icon_px;
`endif

  assign color = COLOR;

endmodule

// File: tb/tb_p18_icon_row_painter.sv
// Randomised bench for p18_icon_row_painter against a frame-level model of
// which icons are lit on each line.
module tb_p18_icon_row_painter;

  localparam int NA           = 200;
  localparam int MAX_ICONS    = 3;
  localparam int ICON_W       = 24;
  localparam int ICON_H       = 4;
  localparam int SPACING      = 16;
  localparam int X_START      = 16;
  localparam int Y_POS        = 474;
  localparam int BLINK_FRAMES = 60;
  localparam int BLINK_HALF   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       hactive;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic [1:0] count;
  logic [2:0] count4;
  logic       in_icon;
  logic       in_icon4;
  logic [5:0] color;
  logic [5:0] color4;

  int checks = 0;
  int errors = 0;

  // Model: icons shown, and the start frame of the current blink, if any.
  int mShown;
  int mPrev;
  int mTick;
  int mBlinkStart;
  bit mBlinkOn;

  p18_icon_row_painter dut (
    .clk    (clk),
    .rst    (rst),
    .hactive(hactive),
    .hpos   (hpos),
    .vpos   (vpos),
    .count  (count),
    .in_icon(in_icon),
    .color  (color)
  );

  p18_icon_row_painter #(.MAX_ICONS(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .hactive(hactive),
    .hpos   (hpos),
    .vpos   (vpos),
    .count  (count4),
    .in_icon(in_icon4),
    .color  (color4)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mShown      = 0;
    mPrev       = 0;
    mTick       = 0;
    mBlinkStart = 0;
    mBlinkOn    = 0;
  endtask

  task automatic modelTick(input int raw);
    int c;
    c = (raw > MAX_ICONS) ? MAX_ICONS : raw;
    mTick++;
    if ((c < mShown) && (BLINK_FRAMES > 0)) begin
      mBlinkOn    = 1;
      mBlinkStart = mTick;
      mPrev       = mShown;
    end else if (mBlinkOn && ((mTick - mBlinkStart >= BLINK_FRAMES) ||
                              (c >= mPrev) || (c > mShown))) begin
      mBlinkOn = 0;
    end
    mShown = c;
  endtask

  function automatic logic [NA-1:0] expRow(int vp, int limit, int shown, bit phase);
    logic [NA-1:0] r = '0;
    if (vp >= Y_POS && vp < Y_POS + ICON_H)
      for (int i = 0; i < limit; i++)
        if (i < shown || phase)
          for (int c = 0; c < ICON_W; c++)
            r[X_START + i * (ICON_W + SPACING) + c] = 1'b1;
    return r;
  endfunction

  function automatic logic [NA-1:0] modelRow(int vp);
    bit ph;
    ph = mBlinkOn && ((((mTick - mBlinkStart) / BLINK_HALF) % 2) == 0);
    return expRow(vp, mBlinkOn ? mPrev : mShown, mShown, ph);
  endfunction

  task automatic applyTick(input int raw, input int raw4);
    @(posedge clk); #1;
    hactive = 1'b0;
    count   = 2'(raw);
    count4  = 3'(raw4);
    vpos    = 9'd0;
    repeat (3) @(posedge clk);
    #1 vpos = 9'd1;
    repeat (2) @(posedge clk);
    modelTick(raw);
  endtask

  task automatic scanLine(input int vp, output logic [NA-1:0] obs, output logic [NA-1:0] obs4);
    @(posedge clk); #1;
    vpos    = 9'(vp);
    hactive = 1'b0;
    repeat (2) @(posedge clk);
    for (int x = 0; x < NA; x++) begin
      @(posedge clk); #1;
      hactive = 1'b1;
      hpos    = 10'(x);
      #1;
      obs[x]  = in_icon;
      obs4[x] = in_icon4;
    end
    @(posedge clk); #1;
    hactive = 1'b0;
  endtask

  task automatic test_reset();
    logic [NA-1:0] obs, obs4, exp;
    rst = 1'b1; hactive = 1'b1; vpos = 9'd474; count = 2'd3; count4 = 3'd0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (in_icon !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_icon got %b exp 0", in_icon); end
    checks++;
    if (in_icon4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_icon4 got %b exp 0", in_icon4); end
    checks++;
    if (color !== 6'b111111) begin errors++; $display("[TB] FAIL color got %b exp 111111", color); end
    checks++;
    if (color4 !== 6'b111111) begin errors++; $display("[TB] FAIL color4 got %b exp 111111", color4); end
    rst = 1'b0; hactive = 1'b0; count = 2'd0;
    modelReset();
    scanLine(474, obs, obs4);
    exp = modelRow(474);
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL post_reset_row got %h exp %h", obs, exp); end
  endtask

  task automatic test_zero_count();
    logic [NA-1:0] obs, obs4, exp;
    applyTick(0, 0);
    for (int vp = 474; vp <= 475; vp++) begin
      scanLine(vp, obs, obs4);
      exp = modelRow(vp);
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL zero_row line %0d got %h exp %h", vp, obs, exp); end
    end
  endtask

  task automatic test_three_icons();
    logic [NA-1:0] obs, obs4, exp;
    int lines[4] = '{473, 474, 477, 478};
    applyTick(3, 0);
    foreach (lines[k]) begin
      scanLine(lines[k], obs, obs4);
      exp = modelRow(lines[k]);
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL three_row line %0d got %h exp %h", lines[k], obs, exp); end
    end
  endtask

  task automatic test_clamp();
    logic [NA-1:0] obs, obs4, exp;
    int raws[2] = '{5, 7};
    foreach (raws[k]) begin
      applyTick(3, raws[k]);
      scanLine(474, obs, obs4);
      exp = expRow(474, 4, 4, 1'b0);
      checks++;
      if (obs4 !== exp) begin errors++; $display("[TB] FAIL clamp_row count4=%0d got %h exp %h", raws[k], obs4, exp); end
      exp = modelRow(474);
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL clamp_main_row got %h exp %h", obs, exp); end
    end
  endtask

  task automatic test_blink();
    logic [NA-1:0] obs, obs4, exp;
    for (int f = 0; f < 66; f++) begin
      applyTick(2, 7);
      scanLine(475, obs, obs4);
      exp = modelRow(475);
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL blink_row frame %0d got %h exp %h", f, obs, exp); end
    end
  endtask

  task automatic test_abort();
    logic [NA-1:0] obs, obs4, exp;
    applyTick(3, 7);
    for (int f = 0; f < 16; f++) begin
      applyTick((f < 10) ? 2 : 3, 7);
      scanLine(476, obs, obs4);
      exp = modelRow(476);
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL abort_row frame %0d got %h exp %h", f, obs, exp); end
    end
  endtask

  task automatic test_random();
    logic [NA-1:0] obs, obs4, exp;
    int raw, vp;
    for (int f = 0; f < 40; f++) begin
      raw = int'($urandom_range(0, 3));
      vp  = int'($urandom_range(472, 479));
      applyTick(raw, 7);
      scanLine(vp, obs, obs4);
      exp = modelRow(vp);
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL random_row frame %0d count %0d line %0d got %h exp %h", f, raw, vp, obs, exp); end
    end
  endtask

  task automatic test_midline_reset();
    logic [NA-1:0] obs, obs4, exp;
    applyTick(3, 7);
    applyTick(3, 7);
    exp = modelRow(475);
    @(posedge clk); #1;
    vpos = 9'd475; hactive = 1'b0;
    repeat (2) @(posedge clk);
    for (int x = 0; x <= 60; x++) begin
      @(posedge clk); #1;
      hactive = 1'b1;
      hpos    = 10'(x);
      #1;
    end
    checks++;
    if (in_icon !== exp[60]) begin errors++; $display("[TB] FAIL midline_pre_reset got %b exp %b", in_icon, exp[60]); end
    rst = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (in_icon !== 1'b0) begin errors++; $display("[TB] FAIL midline_reset got %b exp 0", in_icon); end
    @(posedge clk); #1;
    rst = 1'b0; hactive = 1'b0;
    modelReset();
    scanLine(475, obs, obs4);
    exp = modelRow(475);
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL after_reset_row got %h exp %h", obs, exp); end
    applyTick(3, 7);
    scanLine(475, obs, obs4);
    exp = modelRow(475);
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL reload_row got %h exp %h", obs, exp); end
  endtask

  initial begin
    rst = 1'b1; hactive = 1'b0; hpos = 10'd0; vpos = 9'd100; count = 2'd0; count4 = 3'd0;
    modelReset();
    test_reset();
    test_zero_count();
    test_three_icons();
    test_clamp();
    test_blink();
    test_abort();
    test_random();
    test_midline_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
